mt_func_ctrl: RTL

MT function controller: validates writes to the MT control register and sequences tape functions to the transport. It generates the one-cycle error set pulses (OPI, NEF, FCE, RMR, ILR, ILF) consumed by the MT error register. It also generates the start strobe, busy and attention (ATA) status. It sits between the MT register decoder and the transport/drive model.

---
 rtl/mt_func_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mt_func_ctrl.sv
// mt_func_ctrl: MT function controller.
// Validates GO writes to the control register, sequences motion functions to
// the transport and produces the registered one-cycle error set strobes,
// start strobe, busy and attention status.
// Optional macro MT_TIMEOUT_EN: when defined, a RUN watchdog flags operation
// incomplete after TIMEOUT cycles; when undefined, RUN waits for mtDONE forever.
module mt_func_ctrl #(
    parameter int TIMEOUT = 100000,
    parameter int CNTW    = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mtINIT,
    input  logic       mtWRCS1,
    input  logic       mtGO,
    input  logic [4:0] mtFUN,
    input  logic       mtILLREG,
    input  logic       mtWRPROT,
    input  logic       mtDRVRDY,
    input  logic       mtWRL,
    input  logic       mtFCZ,
    input  logic       mtDONE,
    input  logic       mtCLRATA,
    output logic       mtSTART,
    output logic [4:0] mtFUNC,
    output logic       mtBUSY,
    output logic       mtATA,
    output logic       mtDRVCLR,
    output logic       mtSETOPI,
    output logic       mtSETNEF,
    output logic       mtSETFCE,
    output logic       mtSETRMR,
    output logic       mtSETILR,
    output logic       mtSETILF
);

    // The watchdog counter must be able to represent TIMEOUT-1.
    generate
        if ((longint'(1) << CNTW) <= longint'(TIMEOUT)) begin : gBadCntw
            $error("mt_func_ctrl: CNTW too narrow for TIMEOUT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t     state, stateNext;
    logic [4:0] funcNext;
    logic       startNext, busyNext, ataSet, ataClr, drvClrNext;
    logic       opiNext, nefNext, fceNext, rmrNext, ilfNext;
    logic       goWr, clrAll, timeout;

    assign goWr   = mtWRCS1 & mtGO;
    assign clrAll = rst | mtINIT;

    function automatic logic isLegal(input logic [4:0] f);
        case (f)
            5'o00, 5'o01, 5'o03, 5'o04, 5'o10, 5'o12, 5'o13,
            5'o14, 5'o15, 5'o24, 5'o27, 5'o30, 5'o34, 5'o37: isLegal = 1'b1;
            default:                                         isLegal = 1'b0;
        endcase
    endfunction

    function automatic logic isImm(input logic [4:0] f);
        isImm = (f == 5'o00) || (f == 5'o04) || (f == 5'o10);
    endfunction

    function automatic logic isWrite(input logic [4:0] f);
        isWrite = (f == 5'o12) || (f == 5'o13) || (f == 5'o30);
    endfunction

`ifdef MT_TIMEOUT_EN
    logic [CNTW-1:0] timer;

    assign timeout = (state == RUN) && (timer == CNTW'(TIMEOUT - 1));

    // Watchdog: held at 0 outside RUN so every function starts from 0.
    always_ff @(posedge clk) begin
        if (clrAll || state != RUN) timer <= '0;
        else                        timer <= timer + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        stateNext  = state;
        funcNext   = mtFUNC;
        startNext  = 1'b0;
        busyNext   = mtBUSY;
        ataSet     = 1'b0;
        ataClr     = mtCLRATA;
        drvClrNext = 1'b0;
        opiNext    = 1'b0;
        nefNext    = 1'b0;
        fceNext    = 1'b0;
        rmrNext    = 1'b0;
        ilfNext    = 1'b0;
        case (state)
            IDLE: begin
                busyNext = 1'b0;
                if (goWr) begin
                    if (!isLegal(mtFUN)) begin
                        ilfNext = 1'b1;
                        ataSet  = 1'b1;
                    end else if ((!isImm(mtFUN) && !mtDRVRDY) ||
                                 (isWrite(mtFUN) && mtWRL)) begin
                        nefNext = 1'b1;
                        ataSet  = 1'b1;
                    end else if (isImm(mtFUN)) begin
                        // NOP and preset finish here; drive clear also drops attention.
                        if (mtFUN == 5'o04) begin
                            drvClrNext = 1'b1;
                            ataClr     = 1'b1;
                        end
                    end else begin
                        funcNext  = mtFUN;
                        startNext = 1'b1;
                        busyNext  = 1'b1;
                        stateNext = RUN;
                    end
                end
            end
            RUN: begin
                busyNext = 1'b1;
                if (goWr || mtWRPROT) rmrNext = 1'b1;
                // Completion beats a coincident watchdog expiry.
                if (mtDONE) begin
                    stateNext = FINISH;
                end else if (timeout) begin
                    opiNext   = 1'b1;
                    ataSet    = 1'b1;
                    busyNext  = 1'b0;
                    stateNext = IDLE;
                end
            end
            FINISH: begin
                if ((mtFUNC == 5'o14 || mtFUNC == 5'o15) && !mtFCZ) fceNext = 1'b1;
                ataSet    = 1'b1;
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: begin
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

    // State and registered outputs; attention set wins over clear.
    always_ff @(posedge clk) begin
        if (clrAll) begin
            state    <= IDLE;
            mtFUNC   <= 5'd0;
            mtSTART  <= 1'b0;
            mtBUSY   <= 1'b0;
            mtATA    <= 1'b0;
            mtDRVCLR <= 1'b0;
            mtSETOPI <= 1'b0;
            mtSETNEF <= 1'b0;
            mtSETFCE <= 1'b0;
            mtSETRMR <= 1'b0;
            mtSETILR <= 1'b0;
            mtSETILF <= 1'b0;
        end else begin
            state    <= stateNext;
            mtFUNC   <= funcNext;
            mtSTART  <= startNext;
            mtBUSY   <= busyNext;
            mtATA    <= ataSet | (mtATA & ~ataClr);
            mtDRVCLR <= drvClrNext;
            mtSETOPI <= opiNext;
            mtSETNEF <= nefNext;
            mtSETFCE <= fceNext;
            mtSETRMR <= rmrNext;
            mtSETILR <= mtILLREG;
            mtSETILF <= ilfNext;
        end
    end

endmodule
